outport_arb_22: RTL and testbench

OUTPORT_ARB_22 -- requirements
Module: outport_arb_22

---
 rtl/outport_arb_22_pkg.sv | 31 +++
 rtl/arb_pick3.sv | 41 ++++
 rtl/outport_arb_22.sv | 143 ++++++++++++++
 tb/tb_outport_arb_22.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/outport_arb_22_pkg.sv
// Shared definitions for the output-port arbiter: flit field positions,
// source encoding and arbiter state.
package outport_arb_22_pkg;

  // Flag positions counted down from the top of the flit.
  localparam int unsigned TailFromTop = 1;
  localparam int unsigned HeadFromTop = 2;

  typedef enum logic [1:0] {
    SrcN = 2'd0,
    SrcW = 2'd1,
    SrcL = 2'd2
  } src_e;

  typedef enum logic {
    StIdle,
    StLocked
  } state_e;

  // Round-robin successor, N -> W -> L -> N.
  function automatic src_e next_src(input src_e s);
    src_e r;
    unique case (s)
      SrcN:    r = SrcW;
      SrcW:    r = SrcL;
      default: r = SrcN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arb_pick3.sv
// Three-way picker: highest pressure among valid sources wins, ties go to the
// first source met when scanning from rr_ptr_i in N -> W -> L order.
module arb_pick3
  import outport_arb_22_pkg::*;
#(
  parameter int unsigned PW = 4
) (
  input  logic [2:0]         valid_i,
  input  logic [2:0][PW-1:0] pressure_i,
  input  src_e               rr_ptr_i,
  output logic [2:0]         grant_o
);

  logic [2:0]    sum;
  logic [1:0]    idx;
  logic [1:0]    best_idx;
  logic [PW-1:0] best_p;
  logic          found;

  always_comb begin
    grant_o  = '0;
    sum      = '0;
    idx      = '0;
    best_idx = '0;
    best_p   = '0;
    found    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr_i} + 3'(k);
      if (sum > 3'd2) sum = sum - 3'd3;
      idx = sum[1:0];
      // Strict compare keeps the earlier candidate on a tie.
      if (valid_i[idx] && (!found || pressure_i[idx] > best_p)) begin
        found    = 1'b1;
        best_p   = pressure_i[idx];
        best_idx = idx;
      end
    end
    if (found) grant_o[best_idx] = 1'b1;
  end

endmodule

// File: rtl/outport_arb_22.sv
// Output-port arbiter: picks one of the N/W/L input FIFOs, holds the choice for
// a whole packet, and drives a one-deep registered output stage.
module outport_arb_22
  import outport_arb_22_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = 40
) (
  input  logic                fifo_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                N_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  input  logic [WIDTH:0]      N_pressure_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                down_full,
  output logic                proto_err,
  output logic [15:0]         pkt_cnt
);

  localparam int unsigned TailBit = DATASIZE - TailFromTop;
  localparam int unsigned HeadBit = DATASIZE - HeadFromTop;

  state_e              state_q, state_d;
  src_e                lock_src_q, lock_src_d;
  src_e                rr_ptr_q, rr_ptr_d;
  logic [DATASIZE-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                proto_err_q, proto_err_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;

  logic [2:0]          valid;
  logic [2:0]          pick_grant;
  logic [2:0]          grant;
  logic [2:0]          ready;
  logic                can_load;
  logic                pop;
  src_e                pop_src;
  logic [DATASIZE-1:0] pop_flit;

  assign valid = {L_valid_in, W_valid_in, N_valid_in};

  arb_pick3 #(
    .PW (WIDTH + 1)
  ) u_pick (
    .valid_i    (valid),
    .pressure_i ({L_pressure_in, W_pressure_in, N_pressure_in}),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant)
  );

  always_comb begin
    can_load = !out_valid_q || !down_full;
    grant    = (state_q == StIdle) ? pick_grant : (3'b001 << lock_src_q);
    // rst_n gating keeps the pop strobes low while reset is held.
    ready    = grant & valid & {3{can_load & rst_n}};
    pop      = |ready;
    pop_src  = SrcN;
    pop_flit = N_data_in;
    if (ready[1]) begin
      pop_src  = SrcW;
      pop_flit = W_data_in;
    end else if (ready[2]) begin
      pop_src  = SrcL;
      pop_flit = L_data_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_src_d  = lock_src_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    proto_err_d = proto_err_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (out_valid_q && !down_full && out_data_q[TailBit]) pkt_cnt_d = pkt_cnt_q + 16'd1;

    if (pop) begin
      out_data_d  = pop_flit;
      out_valid_d = 1'b1;
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end

    if (pop) begin
      if (state_q == StIdle) begin
        rr_ptr_d = next_src(pop_src);
        if (!pop_flit[HeadBit]) begin
          proto_err_d = 1'b1;
        end else if (!pop_flit[TailBit]) begin
          state_d    = StLocked;
          lock_src_d = pop_src;
        end
      end else begin
        if (pop_flit[TailBit]) begin
          state_d = StIdle;
        end else if (pop_flit[HeadBit]) begin
          proto_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lock_src_q  <= SrcN;
      rr_ptr_q    <= SrcN;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_src_q  <= lock_src_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign fifo_ready_N = ready[0];
  assign fifo_ready_W = ready[1];
  assign fifo_ready_L = ready[2];
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign proto_err    = proto_err_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_outport_arb_22.sv
// Directed bench for outport_arb_22: arbitration order, packet lock,
// backpressure, streaming, protocol error and asynchronous reset.
module tb_outport_arb_22;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned DATASIZE = 40;

  logic                fifo_clk = 1'b0;
  logic                rst_n;
  logic [DATASIZE-1:0] N_data_in, W_data_in, L_data_in;
  logic                N_valid_in, W_valid_in, L_valid_in;
  logic [WIDTH:0]      N_pressure_in, W_pressure_in, L_pressure_in;
  logic                fifo_ready_N, fifo_ready_W, fifo_ready_L;
  logic [DATASIZE-1:0] out_data;
  logic                out_valid;
  logic                down_full;
  logic                proto_err;
  logic [15:0]         pkt_cnt;
  logic [2:0]          rdy;

  int total = 0;
  int bad   = 0;

  outport_arb_22 #(
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) dut (
    .fifo_clk      (fifo_clk),
    .rst_n         (rst_n),
    .N_data_in     (N_data_in),
    .W_data_in     (W_data_in),
    .L_data_in     (L_data_in),
    .N_valid_in    (N_valid_in),
    .W_valid_in    (W_valid_in),
    .L_valid_in    (L_valid_in),
    .N_pressure_in (N_pressure_in),
    .W_pressure_in (W_pressure_in),
    .L_pressure_in (L_pressure_in),
    .fifo_ready_N  (fifo_ready_N),
    .fifo_ready_W  (fifo_ready_W),
    .fifo_ready_L  (fifo_ready_L),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .down_full     (down_full),
    .proto_err     (proto_err),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 fifo_clk = ~fifo_clk;

  // Ready strobes packed as {N, W, L}.
  assign rdy = {fifo_ready_N, fifo_ready_W, fifo_ready_L};

  function automatic logic [DATASIZE-1:0] mk(input bit t, input bit h, input logic [7:0] p);
    return {t, h, 30'b0, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fifo_clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    N_data_in     = '0;
    W_data_in     = '0;
    L_data_in     = '0;
    N_valid_in    = 1'b1;
    W_valid_in    = 1'b0;
    L_valid_in    = 1'b0;
    N_pressure_in = 4'd2;
    W_pressure_in = 4'd5;
    L_pressure_in = 4'd5;
    down_full     = 1'b0;

    // Reset values, N valid to prove the strobes stay low under reset.
    #12;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst proto_err", 64'(proto_err), 64'd0);
    chk("rst pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst ready", 64'(rdy), 64'b000);
    @(negedge fifo_clk);
    rst_n = 1'b1;

    // Priority: pressures 2/5/5 from rr=N -> W, then L on the tie, then N.
    N_data_in  = mk(1, 1, 8'h11);
    W_data_in  = mk(1, 1, 8'h21);
    L_data_in  = mk(1, 1, 8'h31);
    N_valid_in = 1'b1;
    W_valid_in = 1'b1;
    L_valid_in = 1'b1;
    #1;
    chk("prio grant W", 64'(rdy), 64'b010);
    step();
    chk("prio data W", 64'(out_data), 64'(mk(1, 1, 8'h21)));
    chk("prio valid W", 64'(out_valid), 64'd1);
    W_data_in = mk(1, 1, 8'h22);
    #1;
    chk("prio tie grant L", 64'(rdy), 64'b001);
    step();
    chk("prio data L", 64'(out_data), 64'(mk(1, 1, 8'h31)));
    chk("prio pkt 1", 64'(pkt_cnt), 64'd1);
    W_valid_in = 1'b0;
    L_valid_in = 1'b0;
    #1;
    chk("prio grant N", 64'(rdy), 64'b100);
    step();
    chk("prio data N", 64'(out_data), 64'(mk(1, 1, 8'h11)));
    N_valid_in = 1'b0;
    step();
    chk("prio drained", 64'(out_valid), 64'd0);
    chk("prio pkt 3", 64'(pkt_cnt), 64'd3);

    // Packet lock: W 3-flit packet, L at pressure 8 must wait for the tail.
    W_data_in     = mk(0, 1, 8'h41);
    W_pressure_in = 4'd3;
    W_valid_in    = 1'b1;
    #1;
    chk("lock head grant", 64'(rdy), 64'b010);
    step();
    chk("lock head data", 64'(out_data), 64'(mk(0, 1, 8'h41)));
    W_data_in     = mk(0, 0, 8'h42);
    L_data_in     = mk(1, 1, 8'h51);
    L_pressure_in = 4'd8;
    L_valid_in    = 1'b1;
    #1;
    chk("lock body grant", 64'(rdy), 64'b010);
    step();
    chk("lock body data", 64'(out_data), 64'(mk(0, 0, 8'h42)));
    W_data_in = mk(1, 0, 8'h43);
    #1;
    chk("lock tail grant", 64'(rdy), 64'b010);
    step();
    chk("lock tail data", 64'(out_data), 64'(mk(1, 0, 8'h43)));
    W_valid_in = 1'b0;
    #1;
    chk("lock release L", 64'(rdy), 64'b001);
    step();
    chk("lock L data", 64'(out_data), 64'(mk(1, 1, 8'h51)));
    chk("lock pkt 4", 64'(pkt_cnt), 64'd4);
    L_valid_in = 1'b0;
    step();
    chk("lock pkt 5", 64'(pkt_cnt), 64'd5);
    chk("lock proto_err", 64'(proto_err), 64'd0);

    // Backpressure: 4 full cycles hold the flit and block pops.
    L_data_in  = mk(1, 1, 8'h61);
    L_valid_in = 1'b1;
    step();
    chk("bp first data", 64'(out_data), 64'(mk(1, 1, 8'h61)));
    L_data_in = mk(1, 1, 8'h62);
    down_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp no ready", 64'(rdy), 64'b000);
      step();
      chk("bp data held", 64'(out_data), 64'(mk(1, 1, 8'h61)));
      chk("bp valid held", 64'(out_valid), 64'd1);
    end
    chk("bp pkt held", 64'(pkt_cnt), 64'd5);
    down_full = 1'b0;
    #1;
    chk("bp resume ready", 64'(rdy), 64'b001);
    step();
    chk("bp second data", 64'(out_data), 64'(mk(1, 1, 8'h62)));
    chk("bp pkt 6", 64'(pkt_cnt), 64'd6);
    L_valid_in = 1'b0;
    step();
    chk("bp drained", 64'(out_valid), 64'd0);
    chk("bp pkt 7", 64'(pkt_cnt), 64'd7);

    // Streaming: 10 single-flit packets back to back from L.
    for (int i = 0; i < 10; i++) begin
      L_data_in  = mk(1, 1, 8'(8'h70 + i));
      L_valid_in = 1'b1;
      step();
      chk("stream valid", 64'(out_valid), 64'd1);
      chk("stream data", 64'(out_data), 64'(mk(1, 1, 8'(8'h70 + i))));
    end
    L_valid_in = 1'b0;
    step();
    chk("stream drained", 64'(out_valid), 64'd0);
    chk("stream pkt 17", 64'(pkt_cnt), 64'd17);

    // Protocol error: headless flit in IDLE is forwarded and flagged.
    N_data_in     = mk(0, 0, 8'h81);
    N_pressure_in = 4'd1;
    N_valid_in    = 1'b1;
    #1;
    chk("err grant N", 64'(rdy), 64'b100);
    step();
    chk("err data", 64'(out_data), 64'(mk(0, 0, 8'h81)));
    chk("err flag", 64'(proto_err), 64'd1);
    N_valid_in = 1'b0;
    step();
    step();
    chk("err sticky", 64'(proto_err), 64'd1);
    chk("err pkt 17", 64'(pkt_cnt), 64'd17);

    // Asynchronous reset right after the head of an N packet.
    N_data_in  = mk(0, 1, 8'h91);
    N_valid_in = 1'b1;
    step();
    chk("rmid head data", 64'(out_data), 64'(mk(0, 1, 8'h91)));
    N_data_in = mk(0, 0, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid out_valid", 64'(out_valid), 64'd0);
    chk("rmid out_data", 64'(out_data), 64'd0);
    chk("rmid proto_err", 64'(proto_err), 64'd0);
    chk("rmid pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rmid ready", 64'(rdy), 64'b000);
    @(negedge fifo_clk);
    rst_n         = 1'b1;
    N_pressure_in = 4'd4;
    W_pressure_in = 4'd4;
    L_pressure_in = 4'd4;
    W_valid_in    = 1'b1;
    L_valid_in    = 1'b1;
    #1;
    chk("rmid rr N", 64'(rdy), 64'b100);
    N_valid_in = 1'b0;
    #1;
    chk("rmid idle W", 64'(rdy), 64'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
